// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch sequencer: boot delay, imem handshake, next-PC selection,
// stall/halt/timeout handling and a saturating retired-instruction counter.
module pc_fetch_ctrl #(
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       BOOT_DELAY = 2,
  parameter int unsigned       TIMEOUT    = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              imem_ack,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              stall,
  input  logic              halt,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              instr_valid,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_next,
  output logic              halted,
  output logic              fetch_err,
  output logic [15:0]       retire_count
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_EXEC,
    ST_HALTED
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [3:0]        boot_cnt_q, boot_cnt_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              halted_q, halted_d;
  logic              fetch_err_q, fetch_err_d;
  logic [15:0]       retire_q, retire_d;
  logic              advance;
  logic [ADDR_W-1:0] target;

  // Jump outranks a taken branch, which outranks the sequential successor.
  always_comb begin
    advance = (state_q == ST_EXEC) && !halt && !stall;
    if (jump) begin
      target = jump_target;
    end else if (branch_taken) begin
      target = branch_target;
    end else begin
      target = pc_cur + ADDR_W'(1);
    end
  end

  assign imem_req     = (state_q == ST_FETCH);
  assign imem_addr    = pc_cur;
  assign instr_valid  = (state_q == ST_EXEC);
  assign pc_we        = advance;
  assign pc_next      = (state_q == ST_EXEC) ? target : RESET_PC;
  assign halted       = halted_q;
  assign fetch_err    = fetch_err_q;
  assign retire_count = retire_q;

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    halted_d    = halted_q;
    fetch_err_d = fetch_err_q;
    retire_d    = retire_q;

    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_FETCH;
          wait_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      // An ack in the final allowed wait cycle still wins over the timeout.
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_EXEC;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d     = ST_HALTED;
          halted_d    = 1'b1;
          fetch_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_EXEC: begin
        if (halt) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else if (!stall) begin
          state_d    = ST_FETCH;
          wait_cnt_d = '0;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (advance && (retire_q != 16'hFFFF)) begin
      retire_d = retire_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
      retire_q    <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      halted_q    <= halted_d;
      fetch_err_q <= fetch_err_d;
      retire_q    <= retire_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a small PC register model closing the loop.
module tb_pc_fetch_ctrl;

  logic       clock;
  logic       reset;
  logic [7:0] pc_cur;
  logic       imem_ack;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       jump;
  logic [7:0] jump_target;
  logic       stall;
  logic       halt;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       instr_valid;
  logic       pc_we;
  logic [7:0] pc_next;
  logic       halted;
  logic       fetch_err;
  logic [15:0] retire_count;

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl #(
    .ADDR_W(8),
    .RESET_PC(8'h00),
    .BOOT_DELAY(2),
    .TIMEOUT(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pc_cur(pc_cur),
    .imem_ack(imem_ack),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .stall(stall),
    .halt(halt),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .instr_valid(instr_valid),
    .pc_we(pc_we),
    .pc_next(pc_next),
    .halted(halted),
    .fetch_err(fetch_err),
    .retire_count(retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The PC register the controller drives.
  always @(posedge clock or posedge reset) begin
    if (reset) pc_cur <= 8'h00;
    else if (pc_we) pc_cur <= pc_next;
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    imem_ack = 1'b1;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    jump = 1'b0;
    jump_target = 8'h00;
    stall = 1'b0;
    halt = 1'b0;
    #1;
    checkOutput("rst_req", 32'(imem_req), 32'h0);
    checkOutput("rst_addr", 32'(imem_addr), 32'h0);
    checkOutput("rst_valid", 32'(instr_valid), 32'h0);
    checkOutput("rst_we", 32'(pc_we), 32'h0);
    checkOutput("rst_pcnext", 32'(pc_next), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_ferr", 32'(fetch_err), 32'h0);
    checkOutput("rst_retire", 32'(retire_count), 32'h0);

    #11;
    reset = 1'b0;
    step();
    checkOutput("boot_req_c2", 32'(imem_req), 32'h0);
    step();
    checkOutput("first_req_c3", 32'(imem_req), 32'h1);
    checkOutput("first_addr", 32'(imem_addr), 32'h0);

    // Zero-wait sequential fetches: two cycles per instruction.
    for (int i = 1; i <= 3; i++) begin
      step();
      checkOutput("seq_valid", 32'(instr_valid), 32'h1);
      checkOutput("seq_we", 32'(pc_we), 32'h1);
      checkOutput("seq_pcnext", 32'(pc_next), 32'(i));
      step();
      checkOutput("seq_fetch_we", 32'(pc_we), 32'h0);
      checkOutput("seq_addr", 32'(imem_addr), 32'(i));
      checkOutput("seq_retire", 32'(retire_count), 32'(i));
    end

    step();
    jump = 1'b1;
    jump_target = 8'h40;
    branch_taken = 1'b1;
    branch_target = 8'h20;
    #1;
    checkOutput("jump_wins", 32'(pc_next), 32'h40);
    checkOutput("jump_we", 32'(pc_we), 32'h1);
    step();
    jump = 1'b0;
    #1;
    checkOutput("jump_addr", 32'(imem_addr), 32'h40);
    step();
    checkOutput("branch_pcnext", 32'(pc_next), 32'h20);
    step();
    branch_taken = 1'b0;
    #1;
    checkOutput("branch_addr", 32'(imem_addr), 32'h20);

    step();
    jump = 1'b1;
    jump_target = 8'hFF;
    #1;
    checkOutput("jump_ff", 32'(pc_next), 32'hFF);
    step();
    jump = 1'b0;
    #1;
    checkOutput("addr_ff", 32'(imem_addr), 32'hFF);
    step();
    checkOutput("wrap_pcnext", 32'(pc_next), 32'h00);
    checkOutput("wrap_we", 32'(pc_we), 32'h1);
    step();
    checkOutput("wrap_retire", 32'(retire_count), 32'h7);

    // Three stalled EXEC cycles, then the instruction commits.
    step();
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      checkOutput("stall_valid", 32'(instr_valid), 32'h1);
      checkOutput("stall_we", 32'(pc_we), 32'h0);
      checkOutput("stall_retire", 32'(retire_count), 32'h7);
    end
    step();
    stall = 1'b0;
    #1;
    checkOutput("unstall_we", 32'(pc_we), 32'h1);
    checkOutput("unstall_pcnext", 32'(pc_next), 32'h1);
    step();
    checkOutput("unstall_retire", 32'(retire_count), 32'h8);
    checkOutput("unstall_req", 32'(imem_req), 32'h1);

    step();
    halt = 1'b1;
    #1;
    checkOutput("halt_we", 32'(pc_we), 32'h0);
    checkOutput("halt_valid", 32'(instr_valid), 32'h1);
    step();
    halt = 1'b0;
    #1;
    checkOutput("halt_halted", 32'(halted), 32'h1);
    checkOutput("halt_req", 32'(imem_req), 32'h0);
    checkOutput("halt_ferr", 32'(fetch_err), 32'h0);
    checkOutput("halt_retire", 32'(retire_count), 32'h8);
    step();
    step();
    checkOutput("halt_req_hold", 32'(imem_req), 32'h0);
    checkOutput("halt_sticky", 32'(halted), 32'h1);

    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_halted", 32'(halted), 32'h0);
    checkOutput("async_retire", 32'(retire_count), 32'h0);
    step();
    reset = 1'b0;
    imem_ack = 1'b0;

    // Fetch timeout with no acknowledge.
    step();
    step();
    checkOutput("to_req_first", 32'(imem_req), 32'h1);
    repeat (14) step();
    checkOutput("to_last_halted", 32'(halted), 32'h0);
    checkOutput("to_last_req", 32'(imem_req), 32'h1);
    checkOutput("to_last_ferr", 32'(fetch_err), 32'h0);
    step();
    checkOutput("to_ferr", 32'(fetch_err), 32'h1);
    checkOutput("to_halted", 32'(halted), 32'h1);
    checkOutput("to_req_off", 32'(imem_req), 32'h0);
    imem_ack = 1'b1;
    step();
    checkOutput("to_ack_ignored", 32'(halted), 32'h1);
    checkOutput("to_ack_req", 32'(imem_req), 32'h0);
    checkOutput("to_ack_valid", 32'(instr_valid), 32'h0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("to_rst_ferr", 32'(fetch_err), 32'h0);
    checkOutput("to_rst_halted", 32'(halted), 32'h0);

    // Reset in the middle of a FETCH wait restarts BOOT.
    step();
    reset = 1'b0;
    imem_ack = 1'b0;
    step();
    step();
    checkOutput("mid_req", 32'(imem_req), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_req", 32'(imem_req), 32'h0);
    step();
    reset = 1'b0;
    step();
    checkOutput("reboot_req_c2", 32'(imem_req), 32'h0);
    step();
    checkOutput("reboot_req_c3", 32'(imem_req), 32'h1);
    checkOutput("reboot_addr", 32'(imem_addr), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
